// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
// Shared definitions for the intersection phase scheduler:
//   - light encodings for one approach ({R,Y,G})
//   - phase state enumeration (encoding is visible on the phase_state port)
//   - number of approaches and direction constants
//   - helper to step a direction index round-robin
// -----------------------------------------------------------------------------
package traffic_pkg;

    localparam int N_DIR = 4;

    localparam logic [1:0] DIR_N = 2'd0;
    localparam logic [1:0] DIR_E = 2'd1;
    localparam logic [1:0] DIR_S = 2'd2;
    localparam logic [1:0] DIR_W = 2'd3;

    // {R,Y,G}
    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_GREEN  = 3'b001;

    typedef enum logic [1:0] {
        ALL_RED = 2'd0,
        GREEN   = 2'd1,
        YELLOW  = 2'd2
    } phase_e;

    // Direction k steps after d, wrapping modulo 4 (k = 4 returns d itself).
    function automatic logic [1:0] dir_after(input logic [1:0] d, input int k);
        return d + 2'(k);
    endfunction

endpackage

// File: rtl/approach_queue.sv
// -----------------------------------------------------------------------------
// approach_queue
// Per-approach car queue: detector rising-edge counter with a saturating
// up/down count.
//
// Ports:
//   clk           system clock
//   rst           synchronous reset, active-high (clears count and history)
//   car_detected  raw detector level; each 0->1 transition is one arrival
//   depart        one car leaves this cycle (ignored when count is zero)
//   count         current queue length, saturates at 2^QW-1
// -----------------------------------------------------------------------------
module approach_queue
    import traffic_pkg::*;
#(
    parameter int QW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          car_detected,
    input  logic          depart,
    output logic [QW-1:0] count
);

    logic          hist_q, hist_d;
    logic [QW-1:0] count_q, count_d;
    logic          arrive;

    always_comb begin
        hist_d  = car_detected;
        arrive  = car_detected & ~hist_q;
        count_d = count_q;
        // An arrival and a departure in the same cycle cancel, even when the
        // queue is full or empty.
        unique case ({arrive, depart})
            2'b10: if (count_q != '1) count_d = count_q + QW'(1);
            2'b01: if (count_q != '0) count_d = count_q - QW'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q  <= 1'b0;
            count_q <= '0;
        end else begin
            hist_q  <= hist_d;
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/intersection_phase_scheduler.sv
// -----------------------------------------------------------------------------
// intersection_phase_scheduler
// Shares a single green phase between four approaches (0=N,1=E,2=S,3=W).
// Counts arrivals per approach, drains the active queue during green and
// sequences GREEN -> YELLOW -> ALL_RED with min/max green limits and
// emergency preemption.
//
// Ports:
//   clk            system clock
//   rst            synchronous reset, active-high
//   car_detected   [4]     per-approach detector levels
//   emergency      [1]     emergency vehicle request
//   emergency_dir  [2]     approach requested by the emergency vehicle
//   lights         [12]    {R,Y,G} per approach, approach i at [3i+2:3i]
//   queue_count    [4*QW]  queue of approach i at [QW*i+QW-1:QW*i]
//   active_dir     [2]     approach owning (or last owning) the phase
//   phase_state    [2]     0 ALL_RED, 1 GREEN, 2 YELLOW
//
// Build option LONGEST_QUEUE_EN: when defined, non-emergency selection in
// ALL_RED picks the longest queue (ties resolved in round-robin order from
// active_dir+1); otherwise the first nonzero queue in round-robin order.
// -----------------------------------------------------------------------------
module intersection_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int QW        = 4,
    parameter int MIN_GREEN = 4,
    parameter int MAX_GREEN = 16,
    parameter int YELLOW_T  = 3,
    parameter int ALL_RED_T = 2,
    parameter int DEPART_T  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_DIR-1:0]  car_detected,
    input  logic              emergency,
    input  logic [1:0]        emergency_dir,
    output logic [3*N_DIR-1:0] lights,
    output logic [QW*N_DIR-1:0] queue_count,
    output logic [1:0]        active_dir,
    output logic [1:0]        phase_state
);

    // One shared phase timer; sized for the longest phase it has to count.
    localparam int TMAX_A = (MAX_GREEN > YELLOW_T) ? MAX_GREEN : YELLOW_T;
    localparam int TMAX   = (TMAX_A > ALL_RED_T) ? TMAX_A : ALL_RED_T;
    localparam int TW     = $clog2(TMAX + 1);
    localparam int DW     = (DEPART_T > 1) ? $clog2(DEPART_T) : 1;

    localparam logic [TW-1:0] MING_LAST = TW'(MIN_GREEN - 1);
    localparam logic [TW-1:0] MAXG_LAST = TW'(MAX_GREEN - 1);
    localparam logic [TW-1:0] YEL_LAST  = TW'(YELLOW_T - 1);
    localparam logic [TW-1:0] AR_LAST   = TW'(ALL_RED_T - 1);
    localparam logic [DW-1:0] DEP_LAST  = DW'(DEPART_T - 1);

    phase_e                  state_q, state_d;
    logic [TW-1:0]           tmr_q, tmr_d, tmr_inc;
    logic [DW-1:0]           dep_q, dep_d;
    logic [1:0]              act_q, act_d;
    logic [N_DIR-1:0][2:0]   lights_q, lights_d;

    logic [N_DIR-1:0]        depart;
    logic [N_DIR-1:0][QW-1:0] cnt;

    logic                    sel_ok;
    logic [1:0]              sel_dir;
    logic [1:0]              cand;
`ifdef LONGEST_QUEUE_EN
    logic [QW-1:0]           best;
`endif

    logic                    em_other, em_hold, dep_now, green_done;

    // ------------------------------------------------------------------
    // Per-approach queues
    // ------------------------------------------------------------------
    for (genvar g = 0; g < N_DIR; g++) begin : g_q
        approach_queue #(.QW(QW)) u_queue (
            .clk          (clk),
            .rst          (rst),
            .car_detected (car_detected[g]),
            .depart       (depart[g]),
            .count        (cnt[g])
        );
    end

    // ------------------------------------------------------------------
    // Next-approach selection (only consumed in ALL_RED)
    // ------------------------------------------------------------------
    always_comb begin
        sel_ok  = 1'b0;
        sel_dir = act_q;
        cand    = act_q;
`ifdef LONGEST_QUEUE_EN
        best    = '0;
`endif
        if (emergency) begin
            sel_ok  = 1'b1;
            sel_dir = emergency_dir;
        end else begin
`ifdef LONGEST_QUEUE_EN
            // Strict '>' keeps the earliest round-robin candidate on ties.
            for (int k = 1; k <= N_DIR; k++) begin
                cand = dir_after(act_q, k);
                if (cnt[cand] > best) begin
                    best    = cnt[cand];
                    sel_dir = cand;
                    sel_ok  = 1'b1;
                end
            end
`else
            // Walk backwards so the nearest nonzero queue after act_q wins;
            // k = N_DIR is act_q itself, considered last.
            for (int k = N_DIR; k >= 1; k--) begin
                cand = dir_after(act_q, k);
                if (cnt[cand] != '0) begin
                    sel_dir = cand;
                    sel_ok  = 1'b1;
                end
            end
`endif
        end
    end

    // ------------------------------------------------------------------
    // Phase FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q;
        dep_d    = dep_q;
        act_d    = act_q;
        depart   = '0;
        tmr_inc  = (&tmr_q) ? tmr_q : tmr_q + TW'(1);
        em_other = emergency && (emergency_dir != act_q);
        em_hold  = emergency && (emergency_dir == act_q);
        dep_now  = (dep_q == DEP_LAST);
        // An emergency for the active approach suspends both normal exits.
        green_done = em_other ||
                     (!em_hold && (((tmr_q >= MING_LAST) && (cnt[act_q] == '0)) ||
                                   (tmr_q >= MAXG_LAST)));

        unique case (state_q)
            ALL_RED: begin
                if ((tmr_q >= AR_LAST) && sel_ok) begin
                    state_d = GREEN;
                    act_d   = sel_dir;
                    tmr_d   = '0;
                    dep_d   = '0;
                end else begin
                    tmr_d   = tmr_inc;
                end
            end
            GREEN: begin
                depart[act_q] = dep_now;
                dep_d         = dep_now ? '0 : dep_q + DW'(1);
                if (green_done) begin
                    state_d = YELLOW;
                    tmr_d   = '0;
                end else begin
                    tmr_d   = tmr_inc;
                end
            end
            YELLOW: begin
                if (tmr_q >= YEL_LAST) begin
                    state_d = ALL_RED;
                    tmr_d   = '0;
                end else begin
                    tmr_d   = tmr_inc;
                end
            end
            default: begin
                state_d = ALL_RED;
                tmr_d   = '0;
            end
        endcase
    end

    // Lights are registered from the next state so they line up with state_q.
    always_comb begin
        lights_d = {N_DIR{LIGHT_RED}};
        if (state_d == GREEN)
            lights_d[act_d] = LIGHT_GREEN;
        else if (state_d == YELLOW)
            lights_d[act_d] = LIGHT_YELLOW;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ALL_RED;
            tmr_q    <= '0;
            dep_q    <= '0;
            act_q    <= DIR_N;
            lights_q <= {N_DIR{LIGHT_RED}};
        end else begin
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            dep_q    <= dep_d;
            act_q    <= act_d;
            lights_q <= lights_d;
        end
    end

    assign lights      = lights_q;
    assign queue_count = cnt;
    assign active_dir  = act_q;
    assign phase_state = state_q;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// -----------------------------------------------------------------------------
// Testbench for intersection_phase_scheduler. A phase-duration reference model
// (elapsed cycles per phase, queue lists as integers) predicts all outputs.
// -----------------------------------------------------------------------------
module tb_intersection_phase_scheduler;

    localparam int QW = 4, MIN_GREEN = 4, MAX_GREEN = 16;
    localparam int YELLOW_T = 3, ALL_RED_T = 2, DEPART_T = 2;
    localparam int QMAX = 15;
`ifdef LONGEST_QUEUE_EN
    localparam int NEXT_AFTER_MAX = 0;
`else
    localparam int NEXT_AFTER_MAX = 3;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  car = 4'b0;
    logic        emergency = 1'b0;
    logic [1:0]  emergency_dir = 2'd0;
    logic [11:0] lights;
    logic [15:0] queue_count;
    logic [1:0]  active_dir, phase_state;

    always #5 clk = ~clk;

    intersection_phase_scheduler dut (
        .clk           (clk),
        .rst           (rst),
        .car_detected  (car),
        .emergency     (emergency),
        .emergency_dir (emergency_dir),
        .lights        (lights),
        .queue_count   (queue_count),
        .active_dir    (active_dir),
        .phase_state   (phase_state)
    );

    wire [31:0] obs = {lights, queue_count, active_dir, phase_state};
    localparam logic [31:0] IDLE0 = {12'b100100100100, 16'h0000, 2'd0, 2'd0};

    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- reference model ----------------
    int m_q[4];
    bit m_prev[4];
    int m_phase;   // 0 all-red, 1 green, 2 yellow
    int m_n;       // cycles completed in the current phase
    int m_act;

    function automatic int pick(input logic em, input logic [1:0] ed);
        int best = -1;
        if (em) return int'(ed);
        for (int k = 1; k <= 4; k++) begin
            int d = (m_act + k) % 4;
`ifdef LONGEST_QUEUE_EN
            if (m_q[d] > 0 && (best < 0 || m_q[d] > m_q[best])) best = d;
`else
            if (m_q[d] > 0 && best < 0) best = d;
`endif
        end
        return best;
    endfunction

    task automatic model_step(input logic r, input logic [3:0] c,
                              input logic em, input logic [1:0] ed);
        int n, dep, s;
        bit leave;
        if (r) begin
            for (int i = 0; i < 4; i++) begin m_q[i] = 0; m_prev[i] = 0; end
            m_phase = 0; m_n = 0; m_act = 0;
            return;
        end
        n = m_n + 1; dep = -1; leave = 0;
        case (m_phase)
            0: begin
                m_n = n;
                if (n >= ALL_RED_T) begin
                    s = pick(em, ed);
                    if (s >= 0) begin m_phase = 1; m_act = s; m_n = 0; end
                end
            end
            1: begin
                m_n = n;
                if (n % DEPART_T == 0) dep = m_act;
                if (em && int'(ed) != m_act) leave = 1;
                else if (!(em && int'(ed) == m_act) &&
                         ((n >= MIN_GREEN && m_q[m_act] == 0) || n >= MAX_GREEN)) leave = 1;
                if (leave) begin m_phase = 2; m_n = 0; end
            end
            default: begin
                m_n = n;
                if (n >= YELLOW_T) begin m_phase = 0; m_n = 0; end
            end
        endcase
        for (int i = 0; i < 4; i++) begin
            if (c[i] && !m_prev[i]) begin
                if (dep != i && m_q[i] < QMAX) m_q[i]++;
            end else if (dep == i && m_q[i] > 0) begin
                m_q[i]--;
            end
            m_prev[i] = c[i];
        end
    endtask

    function automatic logic [31:0] exp_bus();
        logic [11:0] l;
        logic [15:0] q;
        l = 12'b100100100100;
        if (m_phase == 1) l[3*m_act +: 3] = 3'b001;
        else if (m_phase == 2) l[3*m_act +: 3] = 3'b010;
        for (int i = 0; i < 4; i++) q[4*i +: 4] = 4'(m_q[i]);
        return {l, q, 2'(m_act), 2'(m_phase)};
    endfunction

    // Advance one clock: model sees the same inputs the DUT samples.
    task automatic tick();
        model_step(rst, car, emergency, emergency_dir);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; car = 4'b0; emergency = 1'b0; emergency_dir = 2'd0;
        tick();
        rst = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; car = 4'b0; emergency = 1'b0;
        tick(); tick();
        n_checks++;
        if (obs !== IDLE0) $display("FAIL reset_state: got %h want %h", obs, IDLE0);
        else n_pass++;
        rst = 1'b0;
        tick();
        n_checks++;
        if (obs !== exp_bus()) $display("FAIL reset_model: got %h want %h", obs, exp_bus());
        else n_pass++;
    endtask

    task automatic test_arrival_drain();
        bit saw_g1 = 0;
        do_reset();
        for (int p = 0; p < 3; p++) begin
            for (int c = 0; c < 30; c++) begin
                car[1] = (c < 20);
                tick();
                if (lights[5:3] == 3'b001) saw_g1 = 1;
                n_checks++;
                if (obs !== exp_bus()) $display("FAIL drain p%0d c%0d: got %h want %h", p, c, obs, exp_bus());
                else n_pass++;
            end
        end
        car[1] = 1'b0;
        repeat (20) tick();
        n_checks++;
        if (!saw_g1) $display("FAIL drain_green1: got no green want green on approach 1");
        else n_pass++;
        n_checks++;
        if (obs !== {12'b100100100100, 16'h0000, 2'd1, 2'd0})
            $display("FAIL drain_idle: got %h want %h", obs, {12'b100100100100, 16'h0000, 2'd1, 2'd0});
        else n_pass++;
    endtask

    task automatic test_saturation();
        do_reset();
        emergency = 1'b1; emergency_dir = 2'd2;
        for (int i = 0; i < 20 && !(phase_state == 2'd1 && active_dir == 2'd2); i++) tick();
        for (int e = 0; e < 20; e++) begin
            car[0] = 1'b1; tick();
            car[0] = 1'b0; tick();
            n_checks++;
            if (obs !== exp_bus()) $display("FAIL sat e%0d: got %h want %h", e, obs, exp_bus());
            else n_pass++;
        end
        n_checks++;
        if (queue_count[3:0] !== 4'd15) $display("FAIL sat_q0: got %0d want 15", queue_count[3:0]);
        else n_pass++;
        n_checks++;
        if ({active_dir, phase_state} !== {2'd2, 2'd1})
            $display("FAIL sat_hold: got dir %0d phase %0d want dir 2 phase 1", active_dir, phase_state);
        else n_pass++;
        emergency = 1'b0;
        for (int c = 0; c < 80; c++) begin
            tick();
            n_checks++;
            if (obs !== exp_bus()) $display("FAIL sat_drain c%0d: got %h want %h", c, obs, exp_bus());
            else n_pass++;
        end
    endtask

    task automatic test_max_green();
        int g0 = 0, q0_exit = -1, next_act = -1;
        bit cap = 0;
        do_reset();
        emergency = 1'b1; emergency_dir = 2'd3;
        for (int i = 0; i < 20 && !(phase_state == 2'd1 && active_dir == 2'd3); i++) tick();
        for (int e = 0; e < 15; e++) begin
            car[0] = 1'b1; tick();
            car[0] = 1'b0; tick();
        end
        emergency = 1'b0;
        tick();
        car[3] = 1'b1; tick();
        car[3] = 1'b0;
        for (int c = 0; c < 200; c++) begin
            tick();
            n_checks++;
            if (obs !== exp_bus()) $display("FAIL maxg c%0d: got %h want %h", c, obs, exp_bus());
            else n_pass++;
            if (phase_state == 2'd1 && active_dir == 2'd0 && !cap) g0++;
            if (g0 > 0 && phase_state == 2'd2 && !cap) begin
                q0_exit = int'(queue_count[3:0]); cap = 1;
            end
            if (cap && phase_state == 2'd1) begin next_act = int'(active_dir); break; end
        end
        n_checks++;
        if (g0 != MAX_GREEN) $display("FAIL maxg_len: got %0d want %0d", g0, MAX_GREEN);
        else n_pass++;
        n_checks++;
        if (q0_exit != 7) $display("FAIL maxg_q0: got %0d want 7", q0_exit);
        else n_pass++;
        n_checks++;
        if (next_act != NEXT_AFTER_MAX) $display("FAIL maxg_next: got %0d want %0d", next_act, NEXT_AFTER_MAX);
        else n_pass++;
    endtask

    task automatic test_emergency();
        int y = 0, ar = 0;
        do_reset();
        car[0] = 1'b1; tick(); car[0] = 1'b0; tick();
        car[0] = 1'b1; tick(); car[0] = 1'b0;
        for (int i = 0; i < 20 && phase_state != 2'd1; i++) tick();
        tick();   // green timer now 1
        emergency = 1'b1; emergency_dir = 2'd2;
        tick();
        n_checks++;
        if (lights !== 12'b100100100010) $display("FAIL emg_yellow: got %b want 100100100010", lights);
        else n_pass++;
        y = 1;
        for (int i = 0; i < 10; i++) begin tick(); if (phase_state == 2'd2) y++; else break; end
        ar = 1;
        for (int i = 0; i < 10; i++) begin tick(); if (phase_state == 2'd0) ar++; else break; end
        n_checks++;
        if (y != YELLOW_T) $display("FAIL emg_ylen: got %0d want %0d", y, YELLOW_T);
        else n_pass++;
        n_checks++;
        if (ar != ALL_RED_T) $display("FAIL emg_arlen: got %0d want %0d", ar, ALL_RED_T);
        else n_pass++;
        n_checks++;
        if ({lights[8:6], queue_count[11:8], phase_state} !== {3'b001, 4'd0, 2'd1})
            $display("FAIL emg_green2: got l=%b q=%0d ph=%0d want l=001 q=0 ph=1",
                     lights[8:6], queue_count[11:8], phase_state);
        else n_pass++;
        for (int c = 0; c < 30; c++) begin
            tick();
            n_checks++;
            if (obs !== exp_bus()) $display("FAIL emg_hold c%0d: got %h want %h", c, obs, exp_bus());
            else n_pass++;
        end
        emergency = 1'b0;
        tick();
        n_checks++;
        if (phase_state !== 2'd2) $display("FAIL emg_release: got phase %0d want 2", phase_state);
        else n_pass++;
    endtask

    task automatic test_same_cycle();
        bit done = 0;
        do_reset();
        emergency = 1'b1; emergency_dir = 2'd0;
        for (int i = 0; i < 20 && phase_state != 2'd1; i++) tick();
        for (int e = 0; e < 7; e++) begin
            car[1] = 1'b1; tick();
            car[1] = 1'b0; tick();
        end
        emergency = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            if (m_phase == 1 && m_act == 1 && (m_n + 1) % DEPART_T == 0 &&
                m_q[1] == 5 && !m_prev[1]) begin
                car[1] = 1'b1; tick(); car[1] = 1'b0;
                done = 1;
                n_checks++;
                if (queue_count[7:4] !== 4'd5) $display("FAIL same_cycle_q1: got %0d want 5", queue_count[7:4]);
                else n_pass++;
            end else begin
                tick();
            end
            n_checks++;
            if (obs !== exp_bus()) $display("FAIL same_cycle c%0d: got %h want %h", c, obs, exp_bus());
            else n_pass++;
        end
        n_checks++;
        if (!done) $display("FAIL same_cycle_reach: got no departure at queue 5 want one");
        else n_pass++;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            car = 4'($urandom) & 4'($urandom);
            if ($urandom_range(0, 99) < 3) emergency = ~emergency;
            if ($urandom_range(0, 99) < 5) emergency_dir = 2'($urandom);
            rst = ($urandom_range(0, 599) == 0);
            tick();
            n_checks++;
            if (obs !== exp_bus()) $display("FAIL rand c%0d: got %h want %h", c, obs, exp_bus());
            else n_pass++;
        end
        rst = 1'b0; emergency = 1'b0;
    endtask

    task automatic test_reset_yellow();
        do_reset();
        car[2] = 1'b1; tick(); car[2] = 1'b0;
        for (int i = 0; i < 40 && phase_state != 2'd2; i++) tick();
        n_checks++;
        if (phase_state !== 2'd2) $display("FAIL rstyel_reach: got phase %0d want 2", phase_state);
        else n_pass++;
        rst = 1'b1; tick(); rst = 1'b0;
        n_checks++;
        if (obs !== IDLE0) $display("FAIL rstyel_state: got %h want %h", obs, IDLE0);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_arrival_drain();
        test_saturation();
        test_max_green();
        test_emergency();
        test_same_cycle();
        test_random();
        test_reset_yellow();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
